cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Producer end of the common data bus: collects completed results (ROB tag + value) from the functional units and broadcasts at most one per cycle on cdb_valid/cdb_tag/cdb_data.
- The reorder buffer and reservation stations consume this broadcast.
- Each functional unit has a one-entry holding slot with a valid/ready handshake; slots are served round-robin; the CDB output is registered.

Parameters:
- NUM_FU, 4, number of functional-unit request ports (>=2)
- DATA_WIDTH, 32, result data width
- TAG_WIDTH, 4, ROB tag width (matches ROB index width)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  squash all held and in-flight results
- fu_valid  input  NUM_FU  per-FU result valid
- fu_ready  output  NUM_FU  per-FU slot can accept
- fu_tag  input  NUM_FU*TAG_WIDTH  per-FU ROB tag, FU i at bits [i*TAG_WIDTH +: TAG_WIDTH]
- fu_data  input  NUM_FU*DATA_WIDTH  per-FU result, FU i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- cdb_valid  output  1  broadcast valid
- cdb_tag  output  TAG_WIDTH  broadcast ROB tag
- cdb_data  output  DATA_WIDTH  broadcast value
- cdb_src  output  $clog2(NUM_FU)  index of the FU whose result is on the bus

Behaviour:
- Reset (rst_n=0 at posedge):
  - all slot_v=0; rr_ptr=0
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0
  - fu_ready reads 0 while rst_n=0
- Slot accept:
  - fu_ready[i] = rst_n & !flush & (!slot_v[i] | grant[i]).
  - At posedge, if fu_valid[i] & fu_ready[i], slot i loads tag/data and sets slot_v[i]=1.
  - A slot granted in the same cycle may be refilled, giving 1 result/cycle per FU sustained.
- Arbitration (combinational on slot_v, each cycle):
  - Search indices rr_ptr, rr_ptr+1, ... mod NUM_FU; the first set slot_v wins (grant one-hot, or zero if none).
  - On a grant to index g, rr_ptr <= (g+1) mod NUM_FU at the next posedge. With no grant, rr_ptr holds.
- Broadcast (registered):
  - At the posedge ending a grant cycle: cdb_valid<=1, cdb_tag/cdb_data<=slot g contents, cdb_src<=g, and slot_v[g] clears unless refilled.
  - With no grant: cdb_valid<=0; tag/data/src hold their previous values.
- Latency:
  - A result accepted at edge k with no contention appears on the CDB with cdb_valid=1 in the cycle after edge k+1.
  - Worst case wait is NUM_FU-1 extra cycles (starvation-free).
- Flush:
  - At posedge with flush=1: all slot_v<=0, cdb_valid<=0, no accept. rr_ptr holds.
  - flush overrides grant and accept in that cycle.
  - Effect visible from the next cycle.
- No backpressure from consumers: the ROB/RS always sample cdb_valid.
- Width rules:
  - Tags and data pass unmodified.
  - rr_ptr wraps modulo NUM_FU; for non-power-of-2 NUM_FU it must wrap explicitly at NUM_FU-1 -> 0.
- Reset mid-operation:
  - Held results are discarded with no broadcast.
  - An FU handshake in the reset cycle is not accepted.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- Defined: adds outputs stat_bcast_cnt (32) and stat_conflict_cnt (32), both reset to 0 by rst_n and not cleared by flush.
  - stat_bcast_cnt increments each posedge where cdb_valid is loaded 1.
  - stat_conflict_cnt increments each cycle with >=2 slot_v set (at least one result waits).
  - Both wrap at 2^32.
- Undefined: the outputs and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with fu_valid=4'b1111 -> cdb_valid=0, fu_ready=0, and after release no broadcast occurs until new handshakes.
- Single result: FU2 presents tag=5, data=32'hDEADBEEF, accepted at edge k -> cycle after edge k+1 shows cdb_valid=1, tag=5, data=DEADBEEF, src=2; next cycle cdb_valid=0.
- Contention: all 4 FUs accepted at the same edge with tags 1..4, rr_ptr=0 -> four consecutive broadcasts of tags 1,2,3,4 (src 0,1,2,3), then rr_ptr=0.
- Fairness: FU0 valid every cycle (tags cycling), FU3 holds one result -> FU3 is broadcast within 2 cycles of entering its slot, and FU0 never gets two consecutive grants while FU3 waits.
- Back-to-back refill: FU1 valid continuously and alone -> fu_ready[1] stays 1, and one broadcast per cycle with tags in order.
- Flush: 3 slots occupied, flush pulsed 1 cycle -> the next cycle has cdb_valid=0, all fu_ready=1, and none of the flushed tags ever appear on the CDB.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer end of the common data bus.
// Each functional unit owns a one-entry holding slot behind a valid/ready
// handshake. Occupied slots are served round-robin, and one result per cycle is
// broadcast on a registered CDB (cdb_valid/cdb_tag/cdb_data/cdb_src).
// Optional feature (macro CDB_ARB_STATS_EN): adds free-running broadcast and
// conflict counters (stat_bcast_cnt, stat_conflict_cnt).
module cdb_arbiter #(
   parameter  int NUM_FU     = 4,
   parameter  int DATA_WIDTH = 32,
   parameter  int TAG_WIDTH  = 4,
   localparam int SRC_W      = $clog2(NUM_FU)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [NUM_FU-1:0]            fu_valid,
   output logic [NUM_FU-1:0]            fu_ready,
   input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
   input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data,
   output logic                         cdb_valid,
   output logic [TAG_WIDTH-1:0]         cdb_tag,
   output logic [DATA_WIDTH-1:0]        cdb_data,
   output logic [SRC_W-1:0]             cdb_src
`ifdef CDB_ARB_STATS_EN
  ,output logic [31:0]                  stat_bcast_cnt,
   output logic [31:0]                  stat_conflict_cnt
`endif
);

   logic [NUM_FU-1:0]     slot_v;
   logic [TAG_WIDTH-1:0]  slot_tag  [NUM_FU];
   logic [DATA_WIDTH-1:0] slot_data [NUM_FU];
   logic [SRC_W-1:0]      rr_ptr;

   logic [NUM_FU-1:0]     grant;
   logic [SRC_W-1:0]      grant_idx;
   logic                  grant_any;
   logic [NUM_FU-1:0]     accept;
   logic [SRC_W:0]        search_sum;
   logic [SRC_W-1:0]      search_idx;

   // A slot can take a new result when it is empty or is being drained this cycle.
   assign fu_ready = {NUM_FU{rst_n & ~flush}} & (~slot_v | grant);
   assign accept   = fu_valid & fu_ready;

   // Round-robin search starting at rr_ptr; first occupied slot wins.
   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      grant      = '0;
      grant_idx  = '0;
      grant_any  = 1'b0;
      search_sum = '0;
      search_idx = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         // One extra bit holds rr_ptr+k (at most 2*NUM_FU-2) before the explicit
         // wrap, so non-power-of-two NUM_FU wraps correctly.
         search_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (search_sum >= (SRC_W+1)'(NUM_FU))
            search_sum = search_sum - (SRC_W+1)'(NUM_FU);
         search_idx = search_sum[SRC_W-1:0];
         if (!grant_any && slot_v[search_idx]) begin
            grant_any         = 1'b1;
            grant[search_idx] = 1'b1;
            grant_idx         = search_idx;
         end
      end
   end

   // Slot occupancy: cleared by reset or flush, drained on grant, set on accept.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n)
         slot_v <= '0;
      else if (flush)
         slot_v <= '0;
      else
         slot_v <= (slot_v & ~grant) | accept;
   end

   // Slot payload capture on handshake.
   // NOTE: the payload storage is deliberately not reset; its contents are only
   // ever read while the matching slot_v bit is set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (accept[i]) begin
            slot_tag[i]  <= fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
            slot_data[i] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Round-robin pointer moves one past the winner; holds on idle or flush.
   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (!flush && grant_any)
         rr_ptr <= (grant_idx == SRC_W'(NUM_FU-1)) ? '0 : grant_idx + SRC_W'(1);
   end

   // Registered broadcast of the winning slot; payload holds when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
      end else if (grant_any) begin
         cdb_valid <= 1'b1;
         cdb_tag   <= slot_tag[grant_idx];
         cdb_data  <= slot_data[grant_idx];
         cdb_src   <= grant_idx;
      end else begin
         cdb_valid <= 1'b0;
      end
   end

`ifdef CDB_ARB_STATS_EN
   // More than one bit is set exactly when clearing the lowest set bit leaves
   // something behind.
   logic conflict;
   assign conflict = |(slot_v & (slot_v - NUM_FU'(1)));

   // Statistics counters; survive flush, wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_bcast_cnt    <= '0;
         stat_conflict_cnt <= '0;
      end else begin
         if (!flush && grant_any)
            stat_bcast_cnt <= stat_bcast_cnt + 32'd1;
         if (conflict)
            stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
      end
   end
`endif

endmodule
